// File: rtl/fetch_stage.sv
// Instruction fetch stage: the PC register, a two-state request/hold FSM, and the decode-stage
// pipeline registers. A fetched word that cannot enter decode because of a stall is parked in a hold buffer.
module fetch_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] IMemRdata,
  input  logic        IMemReady,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusyF
);

  typedef enum logic [0:0] {StReq, StHold} fetchState_e;

  fetchState_e state, stateNext;
  logic [31:0] pcF, pcFNext;
  logic [31:0] instrDNext, pcPlus4DNext;
  logic        validDNext;
  logic [31:0] holdInstr, holdInstrNext;
  logic [31:0] holdPcPlus4, holdPcPlus4Next;

  logic        accept;
  logic        redirect;
  logic [31:0] pcPlus4F;
  logic [31:0] target;

  assign IMemReq    = (state == StReq);
  assign IMemAddr   = pcF;
  assign accept     = (state == StReq) & IMemReady;
  assign FetchBusyF = (state == StReq) & ~IMemReady;
  assign redirect   = ~StallD & (JumpD | PCSrcD);
  assign pcPlus4F   = pcF + 32'd4;
  assign target     = JumpD ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCBranchD;

  always_comb begin
    stateNext       = state;
    pcFNext         = pcF;
    instrDNext      = InstrD;
    pcPlus4DNext    = PCPlus4D;
    validDNext      = ValidD;
    holdInstrNext   = holdInstr;
    holdPcPlus4Next = holdPcPlus4;

    if (redirect) begin
      // Any word accepted this cycle, and any parked word, belongs to the wrong path.
      pcFNext    = target;
      instrDNext = 32'd0;
      validDNext = 1'b0;
      stateNext  = StReq;
    end else begin
      unique case (state)
        StReq: begin
          if (accept) begin
            pcFNext = pcPlus4F;
            if (StallD) begin
              holdInstrNext   = IMemRdata;
              holdPcPlus4Next = pcPlus4F;
              stateNext       = StHold;
            end else begin
              instrDNext   = IMemRdata;
              pcPlus4DNext = pcPlus4F;
              validDNext   = 1'b1;
            end
          end else if (!StallD) begin
            instrDNext = 32'd0;
            validDNext = 1'b0;
          end
        end
        StHold: begin
          if (!StallD) begin
            instrDNext   = holdInstr;
            pcPlus4DNext = holdPcPlus4;
            validDNext   = 1'b1;
            stateNext    = StReq;
          end
        end
        default: stateNext = StReq;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= StReq;
      pcF         <= 32'd0;
      InstrD      <= 32'd0;
      PCPlus4D    <= 32'd0;
      ValidD      <= 1'b0;
      holdInstr   <= 32'd0;
      holdPcPlus4 <= 32'd0;
    end else begin
      state       <= stateNext;
      pcF         <= pcFNext;
      InstrD      <= instrDNext;
      PCPlus4D    <= pcPlus4DNext;
      ValidD      <= validDNext;
      holdInstr   <= holdInstrNext;
      holdPcPlus4 <= holdPcPlus4Next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the fetch/decode hand-off.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        StallD, PCSrcD, JumpD, IMemReady;
  logic [31:0] PCBranchD, IMemRdata;
  logic        IMemReq, ValidD, FetchBusyF;
  logic [31:0] IMemAddr, InstrD, PCPlus4D;

  bit memMode;
  int nVec = 0;
  int nMis = 0;
  bit chkOn = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .JumpD     (JumpD),
    .PCBranchD (PCBranchD),
    .IMemRdata (IMemRdata),
    .IMemReady (IMemReady),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchBusyF(FetchBusyF)
  );

  // Directed memory returns the address itself, except one jump-instruction word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (!memMode) return (a == 32'h1000_0000) ? 32'h0000_0010 : a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign IMemRdata = memWord(IMemAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a program counter, at most one parked word, and what decode currently holds.
  logic [31:0] mPc, mInstr, mPc4, mHoldInstr, mHoldPc4;
  logic        mValid, mParked;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mPc <= 0; mInstr <= 0; mPc4 <= 0; mValid <= 0; mParked <= 0;
      mHoldInstr <= 0; mHoldPc4 <= 0;
    end else if (!StallD && (JumpD || PCSrcD)) begin
      mPc     <= JumpD ? {mPc4[31:28], mInstr[25:0], 2'b00} : PCBranchD;
      mInstr  <= 0;
      mValid  <= 0;
      mParked <= 0;
    end else if (mParked) begin
      if (!StallD) begin
        mInstr <= mHoldInstr; mPc4 <= mHoldPc4; mValid <= 1; mParked <= 0;
      end
    end else if (IMemReady) begin
      mPc <= mPc + 4;
      if (StallD) begin
        mHoldInstr <= memWord(mPc); mHoldPc4 <= mPc + 4; mParked <= 1;
      end else begin
        mInstr <= memWord(mPc); mPc4 <= mPc + 4; mValid <= 1;
      end
    end else if (!StallD) begin
      mInstr <= 0;
      mValid <= 0;
    end
  end

  always @(negedge CLK) begin
    if (chkOn) begin
      check("IMemReq", {31'd0, IMemReq}, {31'd0, !mParked});
      check("IMemAddr", IMemAddr, mPc);
      check("FetchBusyF", {31'd0, FetchBusyF}, {31'd0, !mParked && !IMemReady});
      check("ValidD", {31'd0, ValidD}, {31'd0, mValid});
      check("InstrD", InstrD, mInstr);
      check("PCPlus4D", PCPlus4D, mPc4);
    end
  end

  task automatic drive(input logic s, input logic p, input logic j, input logic [31:0] b,
                       input logic r);
    StallD = s; PCSrcD = p; JumpD = j; PCBranchD = b; IMemReady = r;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, "_InstrD"}, InstrD, 32'd0);
    check({tag, "_PCPlus4D"}, PCPlus4D, 32'd0);
    check({tag, "_ValidD"}, {31'd0, ValidD}, 32'd0);
    check({tag, "_IMemAddr"}, IMemAddr, 32'd0);
    check({tag, "_IMemReq"}, {31'd0, IMemReq}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1;
    memMode = 0;
    drive(0, 0, 0, 0, 0);
    repeat (2) cyc();
    checkResetVals("rst");
    chkOn = 1;
    Reset = 1'b0;

    // Back-to-back fetch from address 0.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("seq_InstrD", InstrD, 32'(i * 4));
      check("seq_PCPlus4D", PCPlus4D, 32'(i * 4 + 4));
      check("seq_ValidD", {31'd0, ValidD}, 32'd1);
    end

    // Stall while accepting at 0x10: parks the word.
    drive(1, 0, 0, 0, 1);
    cyc();
    check("hold_IMemReq", {31'd0, IMemReq}, 32'd0);
    check("hold_InstrD", InstrD, 32'h0000_000C);
    check("hold_IMemAddr", IMemAddr, 32'h0000_0014);
    cyc();
    check("hold2_IMemReq", {31'd0, IMemReq}, 32'd0);
    check("hold2_InstrD", InstrD, 32'h0000_000C);
    drive(0, 0, 0, 0, 0);
    cyc();
    check("rel_InstrD", InstrD, 32'h0000_0010);
    check("rel_PCPlus4D", PCPlus4D, 32'h0000_0014);
    check("rel_IMemAddr", IMemAddr, 32'h0000_0014);

    // Branch while holding discards the parked word.
    drive(1, 0, 0, 0, 1);
    cyc();
    drive(0, 1, 0, 32'h40, 0);
    cyc();
    check("brh_ValidD", {31'd0, ValidD}, 32'd0);
    check("brh_IMemAddr", IMemAddr, 32'h0000_0040);
    drive(0, 0, 0, 0, 1);
    cyc();
    check("brh_InstrD", InstrD, 32'h0000_0040);

    // Memory not ready for three cycles at 8.
    drive(0, 1, 0, 32'h8, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_FetchBusyF", {31'd0, FetchBusyF}, 32'd1);
      cyc();
      check("wait_ValidD", {31'd0, ValidD}, 32'd0);
      check("wait_IMemAddr", IMemAddr, 32'h0000_0008);
    end
    drive(0, 0, 0, 0, 1);
    cyc();
    check("wait_InstrD", InstrD, 32'h0000_0008);
    check("wait_ValidD1", {31'd0, ValidD}, 32'd1);

    // Jump priority over branch; a stalled jump does not redirect.
    drive(0, 1, 0, 32'h1000_0000, 0);
    cyc();
    drive(0, 0, 0, 0, 1);
    cyc();
    check("jmp_InstrD", InstrD, 32'h0000_0010);
    check("jmp_PCPlus4D", PCPlus4D, 32'h1000_0004);
    drive(1, 0, 1, 0, 0);
    cyc();
    check("jmpstall_IMemAddr", IMemAddr, 32'h1000_0004);
    check("jmpstall_ValidD", {31'd0, ValidD}, 32'd1);
    drive(0, 1, 1, 32'h5555_0000, 0);
    cyc();
    check("jmp_IMemAddr", IMemAddr, 32'h1000_0040);
    check("jmp_ValidD", {31'd0, ValidD}, 32'd0);

    // PC wraps past the top of the address space.
    drive(0, 1, 0, 32'hFFFF_FFFC, 0);
    cyc();
    drive(0, 0, 0, 0, 1);
    cyc();
    check("wrap_InstrD", InstrD, 32'hFFFF_FFFC);
    check("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);
    check("wrap_IMemAddr", IMemAddr, 32'h0000_0000);

    // Asynchronous reset while holding, between clock edges.
    drive(1, 0, 0, 0, 1);
    cyc();
    check("pre_IMemReq", {31'd0, IMemReq}, 32'd0);
    #2 Reset = 1'b1;
    #1 checkResetVals("arst");
    Reset = 1'b0;
    drive(0, 0, 0, 0, 1);
    cyc();
    check("post_InstrD", InstrD, 32'h0000_0000);
    check("post_PCPlus4D", PCPlus4D, 32'h0000_0004);
    check("post_IMemAddr", IMemAddr, 32'h0000_0004);

    // Randomized traffic.
    memMode = 1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 6, $urandom(), $urandom_range(0, 99) < 70);
      Reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    Reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have the port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have the port StallD, input, 1 bit: decode stall from the hazard unit; also freezes fetch.
REQ-004 SHALL have the port PCSrcD, input, 1 bit: branch taken, resolved in decode.
REQ-005 SHALL have the port JumpD, input, 1 bit: jump in decode.
REQ-006 SHALL have the port PCBranchD, input, 32 bits: branch target.
REQ-007 SHALL have the port IMemRdata, input, 32 bits: instruction word for the current IMemAddr.
REQ-008 SHALL have the port IMemReady, input, 1 bit: IMemRdata valid this cycle.
REQ-009 SHALL have the port IMemReq, output, 1 bit: fetch request.
REQ-010 SHALL have the port IMemAddr, output, 32 bits: fetch address, always equal to PCF.
REQ-011 SHALL have the port InstrD, output, 32 bits: decode-stage instruction.
REQ-012 SHALL have the port PCPlus4D, output, 32 bits: decode-stage PC+4.
REQ-013 SHALL have the port ValidD, output, 1 bit: InstrD holds a real instruction, not a bubble.
REQ-014 SHALL have the port FetchBusyF, output, 1 bit: fetch is waiting on memory; consumed by the hazard unit.

Function
REQ-015 SHALL hold an internal PCF register (32 b), a 2-state FSM {REQ, HOLD}, and a hold buffer (instruction + PC+4, 64 b).
REQ-016 SHALL assert IMemReq exactly when state is REQ; memory may see IMemAddr change on any cycle, and IMemRdata/IMemReady refer to the same-cycle IMemAddr.
REQ-017 SHALL define accept = REQ & IMemReady; FetchBusyF = REQ & ~IMemReady (combinational).
REQ-018 SHALL define redirect = ~StallD & (JumpD | PCSrcD); redirect SHALL be ignored while StallD=1.
REQ-019 SHALL compute the next-PC target: JumpD priority -> {PCPlus4D[31:28], InstrD[25:0], 2'b00}; else PCBranchD.
REQ-020 SHALL, on redirect (any state): PCF <= target; InstrD <= 0; ValidD <= 0; state <= REQ; the same-cycle accepted word or hold buffer is discarded.
REQ-021 SHALL, in REQ with accept & ~StallD & ~redirect: InstrD <= IMemRdata; PCPlus4D <= PCF+4; ValidD <= 1; PCF <= PCF+4; stay in REQ.
REQ-022 SHALL, in REQ with accept & StallD: capture {IMemRdata, PCF+4} in the hold buffer; PCF <= PCF+4; go to HOLD; D registers unchanged.
REQ-023 SHALL, in REQ with ~accept & ~StallD & ~redirect: insert a bubble (InstrD <= 0, ValidD <= 0); PCF unchanged.
REQ-024 SHALL, in REQ with ~accept & StallD: change nothing.
REQ-025 SHALL, in HOLD with StallD=1: change nothing; IMemReq=0.
REQ-026 SHALL, in HOLD with ~StallD & ~redirect: InstrD/PCPlus4D <= hold buffer; ValidD <= 1; go to REQ.
REQ-027 SHALL use modulo-2^32 arithmetic for PC+4; 0xFFFFFFFC+4 wraps to 0x00000000 with no flag.
REQ-028 SHALL emit at most one instruction into decode per cycle; no instruction SHALL be duplicated or skipped except on redirect.

Reset
REQ-029 SHALL, when Reset=1 (asynchronous, immediate): PCF=0x00000000, state=REQ, InstrD=0, PCPlus4D=0, ValidD=0, hold buffer=0.
REQ-030 SHALL, with IMemReq=1 and IMemAddr=0 on the first edge after Reset release; a reset mid-request or in HOLD SHALL abandon that request and discard the buffer.

Verification
REQ-031 SHALL cover: reset, then IMemReady=1 with word = addr for 4 cycles -> InstrD 0,4,8,C on consecutive cycles, PCPlus4D 4,8,C,10, ValidD=1.
REQ-032 SHALL cover: IMemReady=0 for 3 cycles at PCF=8 -> FetchBusyF=1 and ValidD=0 for 3 cycles, IMemAddr held at 8, then instruction 8 delivered.
REQ-033 SHALL cover: StallD=1 for 2 cycles while accepting at PCF=0x10 -> HOLD, IMemReq=0, InstrD unchanged; on release InstrD=mem[0x10], next IMemAddr=0x14.
REQ-034 SHALL cover: PCSrcD=1, PCBranchD=0x40 while in HOLD -> ValidD=0 next cycle, buffer discarded, IMemAddr=0x40.
REQ-035 SHALL cover: JumpD=1 and PCSrcD=1 simultaneously, PCPlus4D=0x10000004, InstrD[25:0]=0x0000010 -> PCF=0x10000040; StallD=1 with JumpD=1 -> no redirect.
REQ-036 SHALL cover: PCF=0xFFFFFFFC accepted -> PCPlus4D=0x00000000, next IMemAddr=0; Reset pulse mid-stall -> all outputs at reset values with no clock edge.
